// File: rtl/btn_event_ctrl_if.sv
// Event channel between the button controller and the CPU IO port.
// master: the controller (drives the event register and overflow flag).
// slave:  the consumer (acknowledges events and clears overflow).
interface btn_event_ctrl_if;
  logic       evt_valid;
  logic [3:0] evt_id;
  logic [1:0] evt_type;
  logic       evt_ack;
  logic       overflow;
  logic       ovf_clr;

  modport master (
    output evt_valid, evt_id, evt_type, overflow,
    input  evt_ack, ovf_clr
  );

  modport slave (
    input  evt_valid, evt_id, evt_type, overflow,
    output evt_ack, ovf_clr
  );
endinterface

// File: rtl/btn_event_ctrl.sv
// Push-button input controller.
// Each button has a synchronizer, a tick-based debouncer, an UP/DOWN/LONG
// state machine and one pending-event slot. A round-robin arbiter moves
// pending events into a single valid/ack output register.
// Optional feature: define BTN_AUTO_REPEAT_EN to emit REPEAT events every
// REPEAT_TICKS ticks while a button stays in LONG.

module btn_event_lane #(
  parameter int DB_TICKS     = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_raw,
  input  logic       grant,
  output logic       level,
  output logic       pend_vld,
  output logic [1:0] pend_type,
  output logic       drop
);
  localparam int DBW      = $clog2(DB_TICKS + 1);
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [1:0] EV_REPEAT  = 2'd3;
`endif

  typedef enum logic [1:0] {S_UP, S_DOWN, S_LONG} st_t;

  logic [1:0]     sync_ff;
  logic [DBW-1:0] db_cnt, db_nxt, db_inc;
  logic           lvl_nxt, acc;
  st_t            state, st_nxt;
  logic [HW-1:0]  hold_cnt, hold_nxt, hold_inc;
  logic           raise;
  logic [1:0]     raise_type;

  // Two-flop synchronizer for the raw pin.
  always_ff @(posedge clk) begin
    if (rst) sync_ff <= '0;
    else     sync_ff <= {sync_ff[0], btn_raw};
  end

  // Debounce: count consecutive ticks where the pin disagrees with the level.
  always_comb begin
    db_inc  = db_cnt + 1'b1;
    db_nxt  = db_cnt;
    lvl_nxt = level;
    acc     = 1'b0;
    if (tick) begin
      if (sync_ff[1] == level) begin
        db_nxt = '0;
      end else if (db_inc == DBW'(DB_TICKS)) begin
        db_nxt  = '0;
        lvl_nxt = ~level;
        acc     = 1'b1;
      end else begin
        db_nxt = db_inc;
      end
    end
  end

  // Press/long/release tracking; release wins over LONG/REPEAT on one tick.
  always_comb begin
    hold_inc   = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
    st_nxt     = state;
    hold_nxt   = hold_cnt;
    raise      = 1'b0;
    raise_type = EV_PRESS;
    if (tick) begin
      case (state)
        S_UP: if (acc) begin
          st_nxt     = S_DOWN;
          hold_nxt   = '0;
          raise      = 1'b1;
          raise_type = EV_PRESS;
        end
        S_DOWN: if (acc) begin
          st_nxt     = S_UP;
          raise      = 1'b1;
          raise_type = EV_RELEASE;
        end else begin
          hold_nxt = hold_inc;
          if (hold_inc == HW'(LONG_TICKS)) begin
            st_nxt     = S_LONG;
            raise      = 1'b1;
            raise_type = EV_LONG;
`ifdef BTN_AUTO_REPEAT_EN
            hold_nxt   = '0;
`endif
          end
        end
        S_LONG: if (acc) begin
          st_nxt     = S_UP;
          raise      = 1'b1;
          raise_type = EV_RELEASE;
        end
`ifdef BTN_AUTO_REPEAT_EN
        else begin
          hold_nxt = hold_inc;
          if (hold_inc == HW'(REPEAT_TICKS)) begin
            raise      = 1'b1;
            raise_type = EV_REPEAT;
            hold_nxt   = '0;
          end
        end
`endif
        default: st_nxt = S_UP;
      endcase
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_UP;
      level    <= 1'b0;
      db_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= st_nxt;
      level    <= lvl_nxt;
      db_cnt   <= db_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // A full slot not being drained this cycle cannot take a new event.
  assign drop = raise & pend_vld & ~grant;

  // Pending slot: a same-cycle grant frees room for the new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_type <= EV_PRESS;
    end else if (raise && (!pend_vld || grant)) begin
      pend_vld  <= 1'b1;
      pend_type <= raise_type;
    end else if (grant) begin
      pend_vld  <= 1'b0;
    end
  end
endmodule

module btn_event_ctrl #(
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = 100000,
  parameter int DB_TICKS     = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  btn_event_ctrl_if.master evt
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [N_BTN-1:0]       pend_vld, grant, drop;
  logic [N_BTN-1:0][1:0]  pend_type;
  logic [PW-1:0]          rr_ptr, gnt_idx;
  logic [PW:0]            sum;
  logic                   found, load;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Shared sample tick divider.
  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_event_lane #(
      .DB_TICKS    (DB_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .btn_raw  (btn_in[i]),
      .grant    (grant[i]),
      .level    (btn_level[i]),
      .pend_vld (pend_vld[i]),
      .pend_type(pend_type[i]),
      .drop     (drop[i])
    );
  end

  assign load = ~evt.evt_valid | evt.evt_ack;

  // Round-robin search: first pending slot at or above rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < N_BTN; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_BTN)) sum = sum - (PW+1)'(N_BTN);
      if (!found && pend_vld[sum[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
  end

  // One-hot grant back to the lanes, only when the output register loads.
  always_comb begin
    grant = '0;
    if (load && found) grant[gnt_idx] = 1'b1;
  end

  // Output event register; id/type hold while waiting for ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
      evt.evt_type  <= '0;
      rr_ptr        <= '0;
    end else if (load) begin
      if (found) begin
        evt.evt_valid <= 1'b1;
        evt.evt_id    <= 4'(gnt_idx);
        evt.evt_type  <= pend_type[gnt_idx];
        rr_ptr        <= (gnt_idx == PW'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)              evt.overflow <= 1'b0;
    else if (|drop)       evt.overflow <= 1'b1;
    else if (evt.ovf_clr) evt.overflow <= 1'b0;
  end
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with TICK_DIV=4, DB_TICKS=3,
// LONG_TICKS=10, REPEAT_TICKS=5, N_BTN=4. Cycle 0 is the first cycle
// after reset is released; ticks fall on cycles 3, 7, 11, ...
module tb_btn_event_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_level;

  btn_event_ctrl_if bus();

  btn_event_ctrl #(
    .N_BTN(4), .TICK_DIV(4), .DB_TICKS(3), .LONG_TICKS(10), .REPEAT_TICKS(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .evt      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  typedef struct {
    bit         rst_first;
    int         cyc;
    logic [3:0] btn;
    bit         ack;
    bit         clr;
    logic [3:0] e_lvl;
    bit         e_vld;
    logic [3:0] e_id;
    logic [1:0] e_type;
    bit         e_ovf;
    bit         chk_id;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rf, input int c, input logic [3:0] b, input bit a,
                     input bit cl, input logic [3:0] l, input bit v, input logic [3:0] id,
                     input logic [1:0] t, input bit o, input bit ci);
    vec_t r;
    r = '{rf, c, b, a, cl, l, v, id, t, o, ci};
    vecs.push_back(r);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    cur++;
    bus.evt_ack = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; btn_in = '0; bus.evt_ack = 1'b0; bus.ovf_clr = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur = 0;
  endtask

  int ev_id[$], ev_type[$], ev_cyc[$];
  int exp_type[$], exp_cyc[$];

  initial begin
    bus.evt_ack = 1'b0;
    bus.ovf_clr = 1'b0;

    // A: btn1 press, btn0 glitch, btn1 LONG, btn1 release.
    add(1, 0, 4'b0010,0,0, 4'b0000,0,4'd0,2'd0,0,1);
    add(0,11, 4'b0010,0,0, 4'b0000,0,4'd0,2'd0,0,0);
    add(0,12, 4'b0010,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,13, 4'b0010,0,0, 4'b0010,1,4'd1,2'd0,0,1);
    add(0,20, 4'b0010,1,0, 4'b0010,1,4'd1,2'd0,0,1);
    add(0,21, 4'b0010,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,24, 4'b0011,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,32, 4'b0010,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,36, 4'b0010,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,40, 4'b0010,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,52, 4'b0010,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,53, 4'b0010,0,0, 4'b0010,1,4'd1,2'd2,0,1);
    add(0,54, 4'b0000,0,0, 4'b0010,1,4'd1,2'd2,0,1);
    add(0,55, 4'b0000,1,0, 4'b0010,1,4'd1,2'd2,0,1);
    add(0,56, 4'b0000,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,67, 4'b0000,0,0, 4'b0010,0,4'd0,2'd0,0,0);
    add(0,68, 4'b0000,0,0, 4'b0000,0,4'd0,2'd0,0,0);
    add(0,69, 4'b0000,1,0, 4'b0000,1,4'd1,2'd1,0,1);
    add(0,70, 4'b0000,0,0, 4'b0000,0,4'd0,2'd0,0,0);
    // B: rr_ptr moved to 1, then btn0 and btn3 pressed on the same tick.
    add(1, 0, 4'b0001,0,0, 4'b0000,0,4'd0,2'd0,0,1);
    add(0,13, 4'b0001,1,0, 4'b0001,1,4'd0,2'd0,0,1);
    add(0,14, 4'b0000,0,0, 4'b0001,0,4'd0,2'd0,0,0);
    add(0,29, 4'b0000,1,0, 4'b0000,1,4'd0,2'd1,0,1);
    add(0,32, 4'b1001,0,0, 4'b0000,0,4'd0,2'd0,0,0);
    add(0,44, 4'b1001,0,0, 4'b1001,0,4'd0,2'd0,0,0);
    add(0,45, 4'b1001,0,0, 4'b1001,1,4'd3,2'd0,0,1);
    add(0,46, 4'b1001,0,0, 4'b1001,1,4'd3,2'd0,0,1);
    add(0,47, 4'b1001,1,0, 4'b1001,1,4'd3,2'd0,0,1);
    add(0,48, 4'b1001,1,0, 4'b1001,1,4'd0,2'd0,0,1);
    add(0,49, 4'b1001,0,0, 4'b1001,0,4'd0,2'd0,0,0);
    // C: never ack; PRESS held, RELEASE queued, second PRESS dropped.
    add(1, 0, 4'b0010,0,0, 4'b0000,0,4'd0,2'd0,0,1);
    add(0,13, 4'b0010,0,0, 4'b0010,1,4'd1,2'd0,0,1);
    add(0,14, 4'b0000,0,0, 4'b0010,1,4'd1,2'd0,0,1);
    add(0,28, 4'b0000,0,0, 4'b0000,1,4'd1,2'd0,0,1);
    add(0,30, 4'b0010,0,0, 4'b0000,1,4'd1,2'd0,0,1);
    add(0,43, 4'b0010,0,0, 4'b0000,1,4'd1,2'd0,0,1);
    add(0,44, 4'b0010,0,0, 4'b0010,1,4'd1,2'd0,1,1);
    add(0,46, 4'b0010,0,1, 4'b0010,1,4'd1,2'd0,1,1);
    add(0,47, 4'b0010,0,0, 4'b0010,1,4'd1,2'd0,0,1);
    add(0,48, 4'b0010,1,0, 4'b0010,1,4'd1,2'd0,0,1);
    add(0,49, 4'b0010,1,0, 4'b0010,1,4'd1,2'd1,0,1);
    add(0,50, 4'b0010,0,0, 4'b0010,0,4'd0,2'd0,0,0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      while (cur < vecs[i].cyc) next_cyc();
      btn_in      = vecs[i].btn;
      bus.evt_ack = vecs[i].ack;
      bus.ovf_clr = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_level", i, cur), 32'(btn_level), 32'(vecs[i].e_lvl));
      chk($sformatf("v%0d_c%0d_valid", i, cur), 32'(bus.evt_valid), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d_c%0d_ovf", i, cur), 32'(bus.overflow), 32'(vecs[i].e_ovf));
      if (vecs[i].chk_id) begin
        chk($sformatf("v%0d_c%0d_id", i, cur), 32'(bus.evt_id), 32'(vecs[i].e_id));
        chk($sformatf("v%0d_c%0d_type", i, cur), 32'(bus.evt_type), 32'(vecs[i].e_type));
      end
    end

    // E: hold btn2 ~20 ticks past the press with immediate acks.
    do_reset();
    btn_in = 4'b0100;
    while (cur < 130) begin
      if (cur == 92) btn_in = 4'b0000;
      @(negedge clk);
      if (bus.evt_valid) begin
        ev_id.push_back(int'(bus.evt_id));
        ev_type.push_back(int'(bus.evt_type));
        ev_cyc.push_back(cur);
        bus.evt_ack = 1'b1;
      end
      next_cyc();
    end
`ifdef BTN_AUTO_REPEAT_EN
    exp_type = '{0, 2, 3, 3, 1};
    exp_cyc  = '{13, 53, 73, 93, 105};
`else
    exp_type = '{0, 2, 1};
    exp_cyc  = '{13, 53, 105};
`endif
    chk("long_evt_count", 32'(ev_type.size()), 32'(exp_type.size()));
    for (int i = 0; i < exp_type.size() && i < ev_type.size(); i++) begin
      chk($sformatf("long_evt%0d_type", i), 32'(ev_type[i]), 32'(exp_type[i]));
      chk($sformatf("long_evt%0d_id", i), 32'(ev_id[i]), 32'd2);
      chk($sformatf("long_evt%0d_cycle", i), 32'(ev_cyc[i]), 32'(exp_cyc[i]));
    end

    // F: reset with an event held and btn2 mid-debounce (count 2).
    do_reset();
    btn_in = 4'b0010;
    while (cur < 13) next_cyc();
    @(negedge clk);
    chk("rstmid_pre_valid", 32'(bus.evt_valid), 32'd1);
    btn_in = 4'b0110;
    while (cur < 20) next_cyc();
    rst = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("rstmid_level", 32'(btn_level), 32'd0);
    chk("rstmid_valid", 32'(bus.evt_valid), 32'd0);
    chk("rstmid_id", 32'(bus.evt_id), 32'd0);
    chk("rstmid_type", 32'(bus.evt_type), 32'd0);
    chk("rstmid_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    cur = 0;
    while (cur < 11) next_cyc();
    @(negedge clk);
    chk("rerun_level_c11", 32'(btn_level), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("rerun_level_c12", 32'(btn_level), 32'b0110);
    next_cyc();
    @(negedge clk);
    chk("rerun_valid_c13", 32'(bus.evt_valid), 32'd1);
    chk("rerun_id_c13", 32'(bus.evt_id), 32'd1);
    chk("rerun_type_c13", 32'(bus.evt_type), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Input controller for the board push-buttons, sitting between raw button pins and the CPU's memory-mapped IO port.
- Sequences per-button debouncing from one shared sample tick and tracks press, long-press and release for each button.
- Round-robin scheduling arbitrates pending button events onto a single valid/ack event channel read by the IO interface.

Parameters:
N_BTN, 5, number of buttons (1..16)
TICK_DIV, 100000, clk cycles per sample tick (1 ms at 100 MHz); must be >= 2
DB_TICKS, 20, consecutive disagreeing ticks required to accept a level change
LONG_TICKS, 1000, ticks held (after accepted press) before LONG event
REPEAT_TICKS, 200, ticks between REPEAT events while in LONG (only with BTN_AUTO_REPEAT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_in  in  N_BTN  raw asynchronous button levels, active-high
btn_level  out  N_BTN  debounced stable level per button
evt_valid  out  1  event register holds an unread event
evt_id  out  4  button index of event
evt_type  out  2  0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
evt_ack  in  1  consumer accepts event; meaningful only when evt_valid=1
overflow  out  1  sticky: an event was dropped
ovf_clr  in  1  clears overflow

Behaviour:
- Reset: btn_level=0, evt_valid=0, evt_id=0, evt_type=0, overflow=0. Tick counter, debounce counters, hold counters, pending slots and round-robin pointer (to 0) are all cleared. Reset mid-debounce discards partial counts.
- Sync: two-flop synchronizer per btn_in bit. All logic uses synchronized values.
- Tick: counter 0..TICK_DIV-1. tick=1 for the one cycle where counter==TICK_DIV-1; the counter then wraps to 0.
- Debounce, evaluated only on tick, per button:
  - sync==btn_level: clear db_cnt.
  - Otherwise increment db_cnt. When the incremented value equals DB_TICKS: toggle btn_level, clear db_cnt, raise the event.
  - The btn_level change is visible the cycle after the tick.
- Per-button FSM, states UP, DOWN, LONG; advances only on tick:
  - UP -> DOWN on accepted press; raise PRESS; clear hold_cnt.
  - DOWN: hold_cnt++ each tick. At hold_cnt==LONG_TICKS -> LONG; raise LONG.
  - DOWN or LONG -> UP on accepted release; raise RELEASE. Release takes precedence over LONG/REPEAT on the same tick.
- Pending slot, one per button (valid bit plus type):
  - Raised event with empty slot: store it.
  - Raised event with full slot and no same-cycle grant of that button: drop the new event, set overflow.
  - Grant of a button and new event for it in the same cycle: store the new event, no overflow.
- Arbiter and output register:
  - Output register loads when evt_valid=0, or when evt_valid=1 and evt_ack=1.
  - Source is the first pending button searching upward from rr_ptr, with wrap.
  - On grant: clear that slot; rr_ptr = granted index + 1, mod N_BTN.
  - evt_valid stays low if nothing is pending.
  - Back-to-back delivery: ack in cycle t, next event valid in cycle t+1.
  - Latency: event raised on tick at cycle t -> slot set at t+1 -> evt_valid at t+2, if the register is free.
  - evt_id/evt_type stay stable while evt_valid=1 and evt_ack=0.
- overflow: set has priority over ovf_clr in the same cycle; cleared only by ovf_clr or rst.
- Widths: db_cnt is clog2(DB_TICKS+1) bits and hold_cnt is clog2(max(LONG_TICKS,REPEAT_TICKS)+1) bits. hold_cnt saturates and never wraps.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined:
  - Entering LONG clears hold_cnt.
  - In LONG, hold_cnt++ each tick. At hold_cnt==REPEAT_TICKS raise REPEAT and clear hold_cnt.
  - Repeats until release.
- Undefined:
  - LONG is terminal until release; evt_type 3 is never produced.
  - REPEAT_TICKS is ignored and its counter logic is absent.

Test Plan (TICK_DIV=4, DB_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=5, N_BTN=4):
- btn_in[1] high, steady -> btn_level[1]=1 after 3 ticks (~12-14 cycles plus sync); one event id=1 type=0; ack -> evt_valid=0.
- btn_in[0] glitches high for 2 ticks, then low -> btn_level[0] stays 0, no event.
- Hold btn 2 for 20 ticks, then release -> PRESS, LONG (10 ticks after press), RELEASE in order. With BTN_AUTO_REPEAT_EN: REPEAT at 5 and 10 ticks after LONG, before RELEASE.
- Buttons 0 and 3 pressed on the same tick, rr_ptr=1 -> id 3 delivered first, then id 0 the cycle after ack.
- Never ack; press then release btn 1 -> first PRESS held in the register; a second button-1 event queues in the slot; the third is dropped with overflow=1. ovf_clr -> overflow=0.
- Assert rst mid-debounce (db_cnt=2) and with evt_valid=1 -> next cycle all outputs 0; the press is re-debounced from zero after reset.
